// File: rtl/dp_sched_pkg.sv
// dp_sched_pkg: state encoding, default limits and owner decode shared by the scheduler.
package dp_sched_pkg;
  localparam int MAX_CYCLES_DEF = 512;
  localparam int CNT_W_DEF = 16;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_ABORT  = 3'd4;
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/dp_scheduler_rr_arb2.sv
// rr_arb2: two-way round-robin winner select; rr breaks ties when both request.
module rr_arb2
  import dp_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr,
  output logic       winner,
  output logic       valid
);
  always_comb begin
    valid  = |req;
    winner = &req ? rr : req[1];
  end
endmodule

// File: rtl/dp_scheduler.sv
// dp_scheduler: grants a shared datapath to one of two requesters, launches the controller and aborts on watchdog expiry.
module dp_scheduler
  import dp_sched_pkg::*;
#(
  parameter int MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       owner,
  output logic       ctrl_start,
  output logic       ctrl_rst,
  input  logic       ctrl_done,
  output logic [1:0] done,
  output logic       timeout,
  output logic       busy
);
  logic [2:0] state_q, state_d;
  logic rr_q, rr_d, owner_q, owner_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic win, win_valid, wd_lim;
  rr_arb2 u_arb (.req(req), .rr(rr_q), .winner(win), .valid(win_valid));
  assign wd_lim = wd_q == CNT_W'(MAX_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: begin
        state_d = win_valid ? S_LAUNCH : S_IDLE;
        owner_d = win_valid ? win : owner_q;
      end
      S_LAUNCH: begin
        state_d = S_RUN;
        wd_d    = '0;
      end
      // completion takes priority over the watchdog in the same cycle
      S_RUN: begin
        wd_d    = wd_q + CNT_W'(1);
        state_d = ctrl_done ? S_FINISH : wd_lim ? S_ABORT : S_RUN;
      end
      S_FINISH, S_ABORT: begin
        state_d = S_IDLE;
        rr_d    = ~owner_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      wd_q    <= wd_d;
    end
  end
  always_comb begin
    busy       = state_q != S_IDLE;
    grant      = busy ? onehot2(owner_q) : 2'b00;
    owner      = owner_q;
    ctrl_start = state_q == S_LAUNCH;
    timeout    = state_q == S_ABORT;
    done       = (state_q == S_FINISH || timeout) ? onehot2(owner_q) : 2'b00;
    ctrl_rst   = rst | timeout;
  end
endmodule

// File: tb/tb_dp_scheduler.sv
// tb_dp_scheduler: directed bench with a done-pulse scoreboard over a default-limit and an 8-cycle-limit scheduler.
module tb_dp_scheduler;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req [2];
  logic [1:0] grant [2];
  logic [1:0] done [2];
  logic owner [2];
  logic ctrl_start [2];
  logic ctrl_rst [2];
  logic ctrl_done [2];
  logic timeout [2];
  logic busy [2];
  logic mon_en = 1'b0;
  int checks = 0;
  int failures = 0;
  typedef struct {int d; logic [1:0] done; logic to;} exp_t;
  exp_t exp_q [$];

  always #5 clk = ~clk;

  dp_scheduler u0 (
    .clk(clk), .rst(rst), .req(req[0]), .grant(grant[0]), .owner(owner[0]),
    .ctrl_start(ctrl_start[0]), .ctrl_rst(ctrl_rst[0]), .ctrl_done(ctrl_done[0]),
    .done(done[0]), .timeout(timeout[0]), .busy(busy[0])
  );
  dp_scheduler #(.MAX_CYCLES(8)) u1 (
    .clk(clk), .rst(rst), .req(req[1]), .grant(grant[1]), .owner(owner[1]),
    .ctrl_start(ctrl_start[1]), .ctrl_rst(ctrl_rst[1]), .ctrl_done(ctrl_done[1]),
    .done(done[1]), .timeout(timeout[1]), .busy(busy[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mon_en && done[d] !== 2'b00) begin
        if (exp_q.size() == 0) chk($sformatf("unexpected_done%0d", d), 32'(done[d]), 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_dut", d, e.d);
          chk("sb_done", 32'(done[d]), 32'(e.done));
          chk("sb_timeout", 32'(timeout[d]), 32'(e.to));
        end
      end
    end
  end

  task automatic job(input int d, input logic [1:0] r, input int n, input logic [1:0] g,
                     input logic to, input bit keep);
    req[d] = r;
    tick;
    chk("launch_grant", 32'(grant[d]), 32'(g));
    chk("launch_start", 32'(ctrl_start[d]), 1);
    chk("launch_owner", 32'(owner[d]), 32'(g[1]));
    exp_q.push_back('{d, g, to});
    if (!keep) req[d] = 2'b00;
    for (int i = 1; i <= n; i++) begin
      tick;
      chk("run_start", 32'(ctrl_start[d]), 0);
      chk("run_grant", 32'(grant[d]), 32'(g));
      chk("run_crst", 32'(ctrl_rst[d]), 0);
    end
    ctrl_done[d] = !to;
    tick;
    ctrl_done[d] = 1'b0;
    chk("end_grant", 32'(grant[d]), 32'(g));
    chk("end_timeout", 32'(timeout[d]), 32'(to));
    chk("end_crst", 32'(ctrl_rst[d]), 32'(to));
    chk("end_busy", 32'(busy[d]), 1);
    tick;
    chk("idle_busy", 32'(busy[d]), 0);
    chk("idle_grant", 32'(grant[d]), 0);
    chk("idle_timeout", 32'(timeout[d]), 0);
    chk("idle_crst", 32'(ctrl_rst[d]), 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 2'b00;
      ctrl_done[d] = 1'b0;
    end
    repeat (2) tick;
    for (int d = 0; d < 2; d++) begin
      chk("rst_grant", 32'(grant[d]), 0);
      chk("rst_busy", 32'(busy[d]), 0);
      chk("rst_done", 32'(done[d]), 0);
      chk("rst_start", 32'(ctrl_start[d]), 0);
      chk("rst_timeout", 32'(timeout[d]), 0);
      chk("rst_owner", 32'(owner[d]), 0);
      chk("rst_crst", 32'(ctrl_rst[d]), 1);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    tick;
    chk("crst_release", 32'(ctrl_rst[0]), 0);
    // both requesting held across two jobs: 0 then 1
    job(0, 2'b11, 5, 2'b01, 1'b0, 1'b1);
    job(0, 2'b11, 5, 2'b10, 1'b0, 1'b0);
    // single requester, completion 20 cycles after start, then rr must favour 1
    job(0, 2'b01, 20, 2'b01, 1'b0, 1'b0);
    job(0, 2'b11, 3, 2'b10, 1'b0, 1'b0);
    // stray ctrl_done in IDLE and LAUNCH
    ctrl_done[0] = 1'b1;
    tick;
    chk("stray_idle_busy", 32'(busy[0]), 0);
    req[0] = 2'b01;
    tick;
    chk("stray_launch_start", 32'(ctrl_start[0]), 1);
    req[0] = 2'b00;
    tick;
    chk("stray_run_busy", 32'(busy[0]), 1);
    chk("stray_run_start", 32'(ctrl_start[0]), 0);
    chk("stray_run_grant", 32'(grant[0]), 32'(2'b01));
    ctrl_done[0] = 1'b0;
    tick;
    chk("stray_still_run", 32'(busy[0]), 1);
    exp_q.push_back('{0, 2'b01, 1'b0});
    ctrl_done[0] = 1'b1;
    tick;
    ctrl_done[0] = 1'b0;
    chk("stray_finish_grant", 32'(grant[0]), 32'(2'b01));
    tick;
    chk("stray_idle_after", 32'(busy[0]), 0);
    // reset mid-job with owner 1 and rr=1 beforehand
    req[0] = 2'b10;
    tick;
    chk("mid_rst_grant", 32'(grant[0]), 32'(2'b10));
    req[0] = 2'b00;
    repeat (3) tick;
    chk("mid_rst_busy_pre", 32'(busy[0]), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_crst_comb", 32'(ctrl_rst[0]), 1);
    tick;
    chk("mid_rst_busy", 32'(busy[0]), 0);
    chk("mid_rst_grant0", 32'(grant[0]), 0);
    chk("mid_rst_timeout", 32'(timeout[0]), 0);
    chk("mid_rst_owner", 32'(owner[0]), 0);
    chk("mid_rst_crst", 32'(ctrl_rst[0]), 1);
    rst = 1'b0;
    tick;
    chk("mid_rst_crst_low", 32'(ctrl_rst[0]), 0);
    job(0, 2'b11, 2, 2'b01, 1'b0, 1'b0);
    // 8-cycle watchdog: abort, then completion coincident with the limit
    job(1, 2'b01, 8, 2'b01, 1'b1, 1'b0);
    job(1, 2'b10, 8, 2'b10, 1'b0, 1'b0);
    repeat (3) tick;
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dp_scheduler.md
DP_SCHEDULER -- requirements
Module: dp_scheduler

Interface
REQ-001 Parameter MAX_CYCLES, 512, watchdog limit in clk cycles for one datapath job.
REQ-002 Parameter CNT_W, 16, width of watchdog counter; MAX_CYCLES SHALL be at most 2^CNT_W.
REQ-003 Single clock domain; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req  input  2  per-requester job request, level, bit i = requester i.
REQ-007 grant  output  2  one-hot owner of datapath, held from acceptance until job end.
REQ-008 owner  output  1  index of current owner; drives datapath input-mux select.
REQ-009 ctrl_start  output  1  one-cycle start pulse to the existing controller.
REQ-010 ctrl_rst  output  1  reset to controller and datapath.
REQ-011 ctrl_done  input  1  job-complete indication from the controller.
REQ-012 done  output  2  one-cycle completion pulse to requester i.
REQ-013 timeout  output  1  one-cycle pulse when watchdog aborts a job.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, LAUNCH, RUN, FINISH, ABORT.
REQ-016 IDLE: if any req bit high, select winner, register grant/owner, go LAUNCH; else stay.
REQ-017 Arbitration: round-robin pointer rr; both requesting -> winner = rr; one requesting -> that one.
REQ-018 rr SHALL be set to ~owner on leaving FINISH or ABORT; unchanged otherwise.
REQ-019 LAUNCH: ctrl_start = 1 for exactly this cycle, watchdog cleared to 0, next state RUN.
REQ-020 RUN: watchdog increments each cycle; ctrl_done high -> FINISH; else watchdog = MAX_CYCLES-1 -> ABORT.
REQ-021 ctrl_done and watchdog limit in same RUN cycle -> FINISH wins; no timeout.
REQ-022 ctrl_done in IDLE, LAUNCH, FINISH or ABORT SHALL be ignored.
REQ-023 FINISH: done[owner] = 1 for one cycle, grant stays high this cycle, next state IDLE.
REQ-024 ABORT: ctrl_rst = 1, timeout = 1, done[owner] = 1 for one cycle, next state IDLE.
REQ-025 grant SHALL be 0 in IDLE; owner SHALL hold its last value in IDLE.
REQ-026 Latency: req seen in IDLE at edge k -> grant at k+1, ctrl_start during cycle k+1; ctrl_done seen at edge m -> done pulse during cycle m+1.
REQ-027 req still high in IDLE after done is a new request; no request is queued while busy.
REQ-028 req deasserted by the owner mid-job SHALL NOT cancel the job.
REQ-029 All outputs except ctrl_rst SHALL be registered or decoded from registered state only.

Reset
REQ-030 rst high SHALL force state IDLE, rr 0, owner 0, watchdog 0, grant/done/ctrl_start/timeout/busy 0.
REQ-031 ctrl_rst SHALL equal rst OR (state == ABORT), so controller and datapath reset with the scheduler.
REQ-032 rst asserted mid-job SHALL abandon the job without any done or timeout pulse.

Structure
REQ-033 Package dp_sched_pkg SHALL hold the state encoding and the MAX_CYCLES/CNT_W defaults.
REQ-034 Sub-module rr_arb2 SHALL implement the 2-way round-robin winner selection (req, rr -> winner, valid).

Verification
REQ-035 req=01, ctrl_done returned 20 cycles after ctrl_start -> grant=01 next edge, one ctrl_start pulse, done=01 one cycle after ctrl_done, rr=1.
REQ-036 After reset, req=11 held across 2 jobs -> requester 0 served first, then requester 1; grant never 11.
REQ-037 MAX_CYCLES=8, ctrl_done never asserted -> ABORT after 8 RUN cycles: timeout, ctrl_rst and done[owner] each high exactly one cycle.
REQ-038 ctrl_done coincident with watchdog=MAX_CYCLES-1 -> FINISH, timeout stays 0.
REQ-039 rst pulsed 3 cycles into RUN -> state IDLE, no done/timeout, ctrl_rst high while rst high, rr=0.
REQ-040 Stray ctrl_done in IDLE and LAUNCH -> no state change, no done pulse.
